gfsk_demodulation: RTL and testbench
====================================

Name: gfsk_demodulation

Overview:
Receive-side counterpart of the GFSK modulator. It takes baseband I/Q samples at SAMPLE_PER_SYMBOL samples per bit and recovers the PHY bit stream.
- Frequency discrimination uses the cross product of consecutive samples.
- Bit decisions use integrate-and-dump over one symbol, with a programmable sampling-phase offset.
- Output framing (phy_bit/bit_valid/bit_valid_last) matches the modulator's input, so TX→RX loopback is direct.

Parameters:
SAMPLE_PER_SYMBOL, 8, samples per bit; power of two, minimum 2.
IQ_BIT_WIDTH, 8, signed I/Q sample width.
PHASE_BIT_WIDTH, 3, log2(SAMPLE_PER_SYMBOL); width of sample_phase.
Derived localparams: DISC_BIT_WIDTH = 2*IQ_BIT_WIDTH+1; ACC_BIT_WIDTH = DISC_BIT_WIDTH+PHASE_BIT_WIDTH.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
sample_phase  input  PHASE_BIT_WIDTH  number of discriminator samples skipped before the first symbol window; latched on the first iq_valid of a packet
i_in  input  IQ_BIT_WIDTH  signed I sample
q_in  input  IQ_BIT_WIDTH  signed Q sample
iq_valid  input  1  sample strobe; gaps are allowed
iq_valid_last  input  1  last sample of the packet; meaningful only together with iq_valid
disc_out  output  DISC_BIT_WIDTH  signed discriminator value (debug)
disc_valid  output  1  disc_out strobe
disc_valid_last  output  1  last discriminator value of the packet
phy_bit  output  1  recovered bit
bit_valid  output  1  phy_bit strobe
bit_valid_last  output  1  final bit of the packet

Behaviour:
- Reset (rst==0 at posedge): all outputs, registers, counters, accumulator and latched phase go to 0; FSM goes to IDLE. Reset mid-packet abandons the packet; no partial bit is emitted.
- Stage 1, discriminator (one register stage):
  - On each iq_valid, store (i_in, q_in) as prev.
  - On the first sample of a packet, produce no output and set have_prev.
  - On later samples: disc_out <= i_prev*q_in - q_prev*i_in, full precision, signed. disc_valid=1 for exactly one cycle, 1 cycle after iq_valid.
  - disc_valid_last mirrors iq_valid_last.
  - iq_valid_last clears have_prev, so the next sample starts a new packet.
  - A packet of one sample produces no discriminator output and no bits.
- Stage 2, symbol FSM, acting on disc_valid:
  - IDLE:
    - On disc_valid with phase==0: accumulate it, cnt=1, go to ACC.
    - On disc_valid with phase>0: skip=1, go to SKIP.
  - SKIP:
    - Discard samples; go to ACC once phase samples have been discarded in total.
    - disc_valid_last while in SKIP: emit nothing, go to IDLE.
  - ACC:
    - sum = acc + disc_out (ACC_BIT_WIDTH, sign-extended, no saturation).
    - When cnt+1==SAMPLE_PER_SYMBOL: emit phy_bit = (sum > 0), bit_valid=1, clear acc and cnt, stay in ACC.
    - When disc_valid_last arrives: emit (sum > 0) with bit_valid_last=1 regardless of cnt (a partial final symbol is decided on its partial sum), then go to IDLE.
    - If both conditions hold, emit a single bit with bit_valid_last=1.
- Sign convention: counter-clockwise rotation (positive frequency) → 1. A sum of 0 → 0.
- Latency: bit_valid is asserted exactly 2 cycles after the iq_valid of the sample that completes the symbol.
- The phase is latched when the first iq_valid of a packet is seen (have_prev==0). Changes to sample_phase mid-packet are ignored.
- Outputs are single-cycle pulses. phy_bit holds its value until the next bit_valid.
- Back-to-back packets with no idle cycle between iq_valid_last and the next iq_valid are supported.

Decomposition:
- Shared configuration header: SAMPLE_PER_SYMBOL default (shared with the modulator), IQ_BIT_WIDTH default, FSM state encodings (IDLE=0, SKIP=1, ACC=2).
- One sub-module, fm_discriminator: Stage 1, covering prev registers, have_prev, the cross product and valid/last delay.
- The top level holds the FSM, counters and accumulator.

Test Plan:
- CCW, phase=0, SPS=8: 17 samples cycling (64,0),(0,64),(-64,0),(0,-64) → 16 disc_out=+4096 → bits 1,1; second bit carries bit_valid_last, 2 cycles after sample 17.
- CW, same stimulus with the Q sign flipped → disc_out=-4096, bits 0,0.
- Phase=3, 20 CCW samples → 3 skipped, 16 accumulated → 2 bits of 1, last on the second; then an immediate single-sample packet → no outputs.
- Partial symbol, phase=0, 13 CCW samples → 12 discs → one bit after 8, one after 4 more with bit_valid_last. All-zero I/Q → bits 0. iq_valid gaps of 3 cycles → same bits, latency measured from the completing sample.
- Reset low for 1 cycle after 5 samples of a packet → no bit emitted, outputs 0. The next 9-sample CCW packet → single bit 1 with last.
- Loopback: modulator output (with I/Q) for pattern 0x5A fed in, phase swept 0..7 → at least 6 phases recover 0x5A exactly.

Source files
------------

// File: rtl/gfsk_demodulation_pkg.sv
// Shared configuration for the GFSK receive path: default widths (common with
// the modulator) and the symbol FSM state encoding.
package gfsk_demodulation_pkg;

   // Samples per bit, shared with the modulator so TX and RX agree on the symbol length.
   localparam int SAMPLE_PER_SYMBOL_DEF = 8;
   // Signed I/Q sample width.
   localparam int IQ_BIT_WIDTH_DEF      = 8;
   // log2(SAMPLE_PER_SYMBOL_DEF).
   localparam int PHASE_BIT_WIDTH_DEF   = 3;

   // Symbol FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SKIP = 2'd1,
      ST_ACC  = 2'd2
   } state_t;

   // Width of a full-precision cross product of two IQ samples.
   function automatic int disc_width(input int iq_width);
      return 2 * iq_width + 1;
   endfunction

endpackage

// File: rtl/gfsk_demodulation_fm_discriminator.sv
// FM discriminator: cross product of consecutive I/Q samples, one register
// stage. The first sample of a packet only primes the previous-sample registers.
module fm_discriminator
   import gfsk_demodulation_pkg::*;
#(
   parameter int  IQ_BIT_WIDTH   = IQ_BIT_WIDTH_DEF,
   localparam int DISC_BIT_WIDTH = disc_width(IQ_BIT_WIDTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic signed [IQ_BIT_WIDTH-1:0]   i_in,
   input  logic signed [IQ_BIT_WIDTH-1:0]   q_in,
   input  logic                             iq_valid,
   input  logic                             iq_valid_last,
   output logic                             first_sample,
   output logic signed [DISC_BIT_WIDTH-1:0] disc_out,
   output logic                             disc_valid,
   output logic                             disc_valid_last
);

   localparam int EXT_BITS = DISC_BIT_WIDTH - IQ_BIT_WIDTH;

   logic signed [IQ_BIT_WIDTH-1:0]   i_prev_reg;
   logic signed [IQ_BIT_WIDTH-1:0]   q_prev_reg;
   logic                             have_prev_reg;
   logic signed [DISC_BIT_WIDTH-1:0] disc_reg;
   logic                             disc_valid_reg;
   logic                             disc_last_reg;

   logic signed [DISC_BIT_WIDTH-1:0] i_prev_ext;
   logic signed [DISC_BIT_WIDTH-1:0] q_prev_ext;
   logic signed [DISC_BIT_WIDTH-1:0] i_in_ext;
   logic signed [DISC_BIT_WIDTH-1:0] q_in_ext;
   logic signed [DISC_BIT_WIDTH-1:0] cross_next;

   // Sign-extend to the discriminator width so the products and their
   // difference are exact (the true result always fits DISC_BIT_WIDTH).
   always_comb begin
      i_prev_ext = {{EXT_BITS{i_prev_reg[IQ_BIT_WIDTH-1]}}, i_prev_reg};
      q_prev_ext = {{EXT_BITS{q_prev_reg[IQ_BIT_WIDTH-1]}}, q_prev_reg};
      i_in_ext   = {{EXT_BITS{i_in[IQ_BIT_WIDTH-1]}}, i_in};
      q_in_ext   = {{EXT_BITS{q_in[IQ_BIT_WIDTH-1]}}, q_in};
      cross_next = (i_prev_ext * q_in_ext) - (q_prev_ext * i_in_ext);
   end

   // Previous-sample storage, packet tracking and the registered cross product.
   always_ff @(posedge clk) begin
      if (!rst) begin
         i_prev_reg     <= '0;
         q_prev_reg     <= '0;
         have_prev_reg  <= 1'b0;
         disc_reg       <= '0;
         disc_valid_reg <= 1'b0;
         disc_last_reg  <= 1'b0;
      end else begin
         disc_valid_reg <= 1'b0;
         disc_last_reg  <= 1'b0;
         if (iq_valid) begin
            i_prev_reg    <= i_in;
            q_prev_reg    <= q_in;
            // The last sample closes the packet; the next one starts fresh.
            have_prev_reg <= !iq_valid_last;
            if (have_prev_reg) begin
               disc_reg       <= cross_next;
               disc_valid_reg <= 1'b1;
               disc_last_reg  <= iq_valid_last;
            end
         end
      end
   end

   assign first_sample    = !have_prev_reg;
   assign disc_out        = disc_reg;
   assign disc_valid      = disc_valid_reg;
   assign disc_valid_last = disc_last_reg;

endmodule

// File: rtl/gfsk_demodulation.sv
// GFSK demodulator top: FM discriminator followed by an integrate-and-dump
// symbol FSM with a programmable sampling-phase offset.
module gfsk_demodulation
   import gfsk_demodulation_pkg::*;
#(
   parameter int  SAMPLE_PER_SYMBOL = SAMPLE_PER_SYMBOL_DEF,
   parameter int  IQ_BIT_WIDTH      = IQ_BIT_WIDTH_DEF,
   parameter int  PHASE_BIT_WIDTH   = PHASE_BIT_WIDTH_DEF,
   localparam int DISC_BIT_WIDTH    = disc_width(IQ_BIT_WIDTH)
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [PHASE_BIT_WIDTH-1:0]       sample_phase,
   input  logic signed [IQ_BIT_WIDTH-1:0]   i_in,
   input  logic signed [IQ_BIT_WIDTH-1:0]   q_in,
   input  logic                             iq_valid,
   input  logic                             iq_valid_last,
   output logic signed [DISC_BIT_WIDTH-1:0] disc_out,
   output logic                             disc_valid,
   output logic                             disc_valid_last,
   output logic                             phy_bit,
   output logic                             bit_valid,
   output logic                             bit_valid_last
);

   localparam int ACC_BIT_WIDTH = DISC_BIT_WIDTH + PHASE_BIT_WIDTH;
   // One extra bit so cnt+1 can be compared against SAMPLE_PER_SYMBOL directly.
   localparam int CNT_BIT_WIDTH = PHASE_BIT_WIDTH + 1;
   localparam logic [CNT_BIT_WIDTH-1:0] SYMBOL_LEN = CNT_BIT_WIDTH'(SAMPLE_PER_SYMBOL);

   logic                             first_sample;
   logic signed [DISC_BIT_WIDTH-1:0] disc_val;
   logic                             disc_strobe;
   logic                             disc_last;

   fm_discriminator #(
      .IQ_BIT_WIDTH (IQ_BIT_WIDTH)
   ) u_fm_discriminator (
      .clk             (clk),
      .rst             (rst),
      .i_in            (i_in),
      .q_in            (q_in),
      .iq_valid        (iq_valid),
      .iq_valid_last   (iq_valid_last),
      .first_sample    (first_sample),
      .disc_out        (disc_val),
      .disc_valid      (disc_strobe),
      .disc_valid_last (disc_last)
   );

   logic [PHASE_BIT_WIDTH-1:0] phase_reg;

   state_t                     state_reg,   state_next;
   logic [ACC_BIT_WIDTH-1:0]   acc_reg,     acc_next;
   logic [CNT_BIT_WIDTH-1:0]   cnt_reg,     cnt_next;
   logic [PHASE_BIT_WIDTH-1:0] skip_reg,    skip_next;
   logic                       phy_bit_reg, phy_bit_next;
   logic                       bit_valid_reg, bit_valid_next;
   logic                       bit_last_reg,  bit_last_next;

   logic [ACC_BIT_WIDTH-1:0]   disc_ext;
   logic [ACC_BIT_WIDTH-1:0]   acc_base;
   logic [CNT_BIT_WIDTH-1:0]   cnt_base;
   logic [ACC_BIT_WIDTH-1:0]   sum;
   logic [CNT_BIT_WIDTH-1:0]   cnt_inc;
   logic                       sum_pos;
   logic                       integrate;

   assign disc_ext = {{PHASE_BIT_WIDTH{disc_val[DISC_BIT_WIDTH-1]}}, disc_val};

   // Latch the sampling phase on the first sample of each packet only.
   always_ff @(posedge clk) begin
      if (!rst) begin
         phase_reg <= '0;
      end else if (iq_valid && first_sample) begin
         phase_reg <= sample_phase;
      end
   end

   // FSM state, integrator and output registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         skip_reg      <= '0;
         phy_bit_reg   <= 1'b0;
         bit_valid_reg <= 1'b0;
         bit_last_reg  <= 1'b0;
      end else begin
         state_reg     <= state_next;
         acc_reg       <= acc_next;
         cnt_reg       <= cnt_next;
         skip_reg      <= skip_next;
         phy_bit_reg   <= phy_bit_next;
         bit_valid_reg <= bit_valid_next;
         bit_last_reg  <= bit_last_next;
      end
   end

   // Next-state logic: skip the phase offset, then integrate and dump per symbol.
   always_comb begin
      state_next     = state_reg;
      acc_next       = acc_reg;
      cnt_next       = cnt_reg;
      skip_next      = skip_reg;
      phy_bit_next   = phy_bit_reg;
      bit_valid_next = 1'b0;
      bit_last_next  = 1'b0;
      integrate      = 1'b0;

      // IDLE with zero phase integrates as if it were ACC with an empty window.
      acc_base = (state_reg == ST_ACC) ? acc_reg : '0;
      cnt_base = (state_reg == ST_ACC) ? cnt_reg : '0;
      sum      = acc_base + disc_ext;
      cnt_inc  = cnt_base + CNT_BIT_WIDTH'(1);
      // Strictly positive sum means counter-clockwise rotation; zero decides 0.
      sum_pos  = !sum[ACC_BIT_WIDTH-1] && (|sum);

      if (disc_strobe) begin
         case (state_reg)
            ST_IDLE: begin
               if (phase_reg == '0) begin
                  integrate = 1'b1;
               end else if (disc_last) begin
                  state_next = ST_IDLE;
               end else if (phase_reg == PHASE_BIT_WIDTH'(1)) begin
                  state_next = ST_ACC;
                  acc_next   = '0;
                  cnt_next   = '0;
               end else begin
                  skip_next  = PHASE_BIT_WIDTH'(1);
                  state_next = ST_SKIP;
               end
            end
            ST_SKIP: begin
               if (disc_last) begin
                  state_next = ST_IDLE;
                  skip_next  = '0;
               end else if ((skip_reg + PHASE_BIT_WIDTH'(1)) == phase_reg) begin
                  state_next = ST_ACC;
                  skip_next  = '0;
                  acc_next   = '0;
                  cnt_next   = '0;
               end else begin
                  skip_next  = skip_reg + PHASE_BIT_WIDTH'(1);
               end
            end
            ST_ACC: begin
               integrate = 1'b1;
            end
            default: begin
               state_next = ST_IDLE;
               acc_next   = '0;
               cnt_next   = '0;
               skip_next  = '0;
            end
         endcase

         if (integrate) begin
            if (disc_last) begin
               // End of packet: decide on whatever has been integrated so far.
               phy_bit_next   = sum_pos;
               bit_valid_next = 1'b1;
               bit_last_next  = 1'b1;
               acc_next       = '0;
               cnt_next       = '0;
               state_next     = ST_IDLE;
            end else if (cnt_inc == SYMBOL_LEN) begin
               phy_bit_next   = sum_pos;
               bit_valid_next = 1'b1;
               acc_next       = '0;
               cnt_next       = '0;
               state_next     = ST_ACC;
            end else begin
               acc_next   = sum;
               cnt_next   = cnt_inc;
               state_next = ST_ACC;
            end
         end
      end
   end

   assign disc_out        = disc_val;
   assign disc_valid      = disc_strobe;
   assign disc_valid_last = disc_last;
   assign phy_bit         = phy_bit_reg;
   assign bit_valid       = bit_valid_reg;
   assign bit_valid_last  = bit_last_reg;

endmodule

// File: tb/tb_gfsk_demodulation.sv
// Self-checking bench for gfsk_demodulation: directed and random packets are
// recorded as driven, then compared against a packet-level reference model.
module tb_gfsk_demodulation;

   localparam int SPS = 8;
   localparam int IQW = 8;
   localparam int PW  = 3;
   localparam int DW  = 2 * IQW + 1;

   localparam int K_CCW  = 0;
   localparam int K_CW   = 1;
   localparam int K_ZERO = 2;
   localparam int K_RAND = 3;
   localparam int K_DATA = 4;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [PW-1:0]         sample_phase;
   logic signed [IQW-1:0] i_in;
   logic signed [IQW-1:0] q_in;
   logic                  iq_valid;
   logic                  iq_valid_last;
   logic [DW-1:0]         disc_out;
   logic                  disc_valid;
   logic                  disc_valid_last;
   logic                  phy_bit;
   logic                  bit_valid;
   logic                  bit_valid_last;

   gfsk_demodulation #(
      .SAMPLE_PER_SYMBOL (SPS),
      .IQ_BIT_WIDTH      (IQW),
      .PHASE_BIT_WIDTH   (PW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .sample_phase    (sample_phase),
      .i_in            (i_in),
      .q_in            (q_in),
      .iq_valid        (iq_valid),
      .iq_valid_last   (iq_valid_last),
      .disc_out        (disc_out),
      .disc_valid      (disc_valid),
      .disc_valid_last (disc_valid_last),
      .phy_bit         (phy_bit),
      .bit_valid       (bit_valid),
      .bit_valid_last  (bit_valid_last)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   typedef struct {
      int i;
      int q;
      bit last;
      bit abort;
      int phase;
      int cyc;
   } smp_t;

   typedef struct {
      int val;
      bit last;
      int cyc;
   } evt_t;

   smp_t smp_q[$];
   evt_t disc_q[$];
   evt_t bit_q[$];
   smp_t pkt_q[$];
   evt_t exp_d[$];
   evt_t exp_b[$];
   int   cyc = 0;

   // Record every accepted sample, reset cycle and output strobe with its cycle index.
   always @(negedge clk) begin
      smp_t s;
      evt_t e;
      if (!rst) begin
         s.i = 0; s.q = 0; s.last = 1'b0; s.abort = 1'b1; s.phase = 0; s.cyc = cyc;
         smp_q.push_back(s);
      end else if (iq_valid) begin
         s.i = int'(i_in); s.q = int'(q_in); s.last = iq_valid_last; s.abort = 1'b0;
         s.phase = int'(sample_phase); s.cyc = cyc;
         smp_q.push_back(s);
      end
      if (disc_valid || disc_valid_last) begin
         e.val = disc_valid ? int'($signed(disc_out)) : 999999;
         e.last = disc_valid_last; e.cyc = cyc;
         disc_q.push_back(e);
      end
      if (bit_valid || bit_valid_last) begin
         e.val = bit_valid ? int'(phy_bit) : 2;
         e.last = bit_valid_last; e.cyc = cyc;
         bit_q.push_back(e);
      end
      cyc++;
   end

   // Reference model for one packet held in pkt_q: discriminator values are the
   // cross products of neighbours; bits are sign decisions on SPS-long windows
   // after skipping 'phase' values; a partial tail only counts on a proper end.
   task automatic model_packet(input bit ended);
      int d[$];
      int n;
      int p;
      int nd;
      evt_t e;
      n = pkt_q.size();
      for (int k = 0; k + 1 < n; k++) begin
         d.push_back(pkt_q[k].i * pkt_q[k+1].q - pkt_q[k].q * pkt_q[k+1].i);
         e.val = d[k]; e.last = ended && (k == n - 2); e.cyc = pkt_q[k+1].cyc + 1;
         exp_d.push_back(e);
      end
      if (n == 0) return;
      p  = pkt_q[0].phase;
      nd = d.size();
      for (int j = p; j < nd; j += SPS) begin
         int last_idx;
         int sum;
         last_idx = (j + SPS - 1 > nd - 1) ? nd - 1 : j + SPS - 1;
         if ((last_idx - j + 1 < SPS) && !ended) break;
         sum = 0;
         for (int t = j; t <= last_idx; t++) sum += d[t];
         e.val = (sum > 0) ? 1 : 0;
         e.last = ended && (last_idx == nd - 1);
         e.cyc = pkt_q[last_idx+1].cyc + 2;
         exp_b.push_back(e);
      end
   endtask

   // Split the recorded samples into packets, run the model, compare, clear.
   task automatic score(input string name);
      exp_d.delete();
      exp_b.delete();
      pkt_q.delete();
      foreach (smp_q[k]) begin
         if (smp_q[k].abort) begin
            model_packet(1'b0);
            pkt_q.delete();
         end else begin
            pkt_q.push_back(smp_q[k]);
            if (smp_q[k].last) begin
               model_packet(1'b1);
               pkt_q.delete();
            end
         end
      end
      model_packet(1'b0);
      pkt_q.delete();

      check_val({name, " disc count"}, disc_q.size(), exp_d.size());
      for (int k = 0; k < disc_q.size() && k < exp_d.size(); k++) begin
         check_val($sformatf("%s disc[%0d] value", name, k), disc_q[k].val, exp_d[k].val);
         check_val($sformatf("%s disc[%0d] last", name, k), disc_q[k].last, exp_d[k].last);
         check_val($sformatf("%s disc[%0d] cycle", name, k), disc_q[k].cyc, exp_d[k].cyc);
      end
      check_val({name, " bit count"}, bit_q.size(), exp_b.size());
      for (int k = 0; k < bit_q.size() && k < exp_b.size(); k++) begin
         check_val($sformatf("%s bit[%0d] value", name, k), bit_q[k].val, exp_b[k].val);
         check_val($sformatf("%s bit[%0d] last", name, k), bit_q[k].last, exp_b[k].last);
         check_val($sformatf("%s bit[%0d] cycle", name, k), bit_q[k].cyc, exp_b[k].cyc);
      end
      $display("%s: %0d samples, %0d discs, %0d bits", name, smp_q.size(), disc_q.size(), bit_q.size());
      smp_q.delete();
      disc_q.delete();
      bit_q.delete();
   endtask

   function automatic void rot(input int r, input int a, output int iv, output int qv);
      case (((r % 4) + 4) % 4)
         0:       begin iv = a;  qv = 0;  end
         1:       begin iv = 0;  qv = a;  end
         2:       begin iv = -a; qv = 0;  end
         default: begin iv = 0;  qv = -a; end
      endcase
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         iq_valid = 1'b0; iq_valid_last = 1'b0;
      end
   endtask

   task automatic send(input int iv, input int qv, input bit last, input int gap, input int ph);
      repeat (gap) begin
         @(posedge clk); #1;
         iq_valid = 1'b0; iq_valid_last = 1'b0;
         i_in = IQW'($urandom); q_in = IQW'($urandom);
      end
      @(posedge clk); #1;
      iq_valid = 1'b1; iq_valid_last = last;
      i_in = IQW'(iv); q_in = IQW'(qv);
      sample_phase = PW'(ph);
   endtask

   // sample_phase is only honoured on the first sample; later samples carry noise.
   task automatic send_pkt(input int n, input int kind, input int gap_lo, input int gap_hi,
                           input int ph, input bit term);
      int r;
      int dir;
      int iv;
      int qv;
      r = 0; dir = 1;
      for (int k = 0; k < n; k++) begin
         case (kind)
            K_CCW:  rot(k, 64, iv, qv);
            K_CW:   begin rot(k, 64, iv, qv); qv = -qv; end
            K_ZERO: begin iv = 0; qv = 0; end
            K_RAND: begin
               iv = int'($urandom_range(0, 255)) - 128;
               qv = int'($urandom_range(0, 255)) - 128;
            end
            default: begin
               if (k % SPS == 0) dir = ($urandom_range(0, 1) == 1) ? 1 : -1;
               r += dir;
               rot(r, 90, iv, qv);
            end
         endcase
         send(iv, qv, term && (k == n - 1), int'($urandom_range(gap_lo, gap_hi)),
              (k == 0) ? ph : int'($urandom_range(0, SPS - 1)));
      end
   endtask

   initial begin
      rst = 1'b0; sample_phase = '0; i_in = '0; q_in = '0;
      iq_valid = 1'b0; iq_valid_last = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_val("reset phy_bit", phy_bit, 0);
      check_val("reset bit_valid", bit_valid, 0);
      check_val("reset disc_valid", disc_valid, 0);
      check_val("reset disc_out", disc_out, 0);
      rst = 1'b1;

      send_pkt(17, K_CCW, 0, 0, 0, 1'b1); idle(6); score("ccw");
      send_pkt(17, K_CW, 0, 0, 0, 1'b1);  idle(6); score("cw");
      send_pkt(20, K_CCW, 0, 0, 3, 1'b1);
      send_pkt(1, K_CCW, 0, 0, 0, 1'b1);  idle(6); score("phase3+single");
      send_pkt(13, K_CCW, 0, 0, 0, 1'b1); idle(6); score("partial");
      send_pkt(17, K_ZERO, 0, 0, 0, 1'b1); idle(6); score("zero");
      send_pkt(17, K_CCW, 3, 3, 0, 1'b1); idle(6); score("gaps");

      // Reset in the middle of a packet: nothing from it may survive.
      send_pkt(5, K_CCW, 0, 0, 0, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0; iq_valid = 1'b0; iq_valid_last = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      check_val("midreset phy_bit", phy_bit, 0);
      check_val("midreset bit_valid", bit_valid, 0);
      check_val("midreset bit_valid_last", bit_valid_last, 0);
      check_val("midreset disc_valid", disc_valid, 0);
      check_val("midreset disc_out", disc_out, 0);
      send_pkt(9, K_CCW, 0, 0, 0, 1'b1); idle(6); score("reset");

      for (int ph = 0; ph < SPS; ph++) begin
         send_pkt(30, K_DATA, 0, 1, ph, 1'b1);
         idle(2);
      end
      idle(6); score("sweep");

      for (int p = 0; p < 40; p++) begin
         send_pkt(int'($urandom_range(1, 40)), int'($urandom_range(0, 4)), 0,
                  int'($urandom_range(0, 1)) * 2, int'($urandom_range(0, SPS - 1)), 1'b1);
         if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
      end
      idle(6); score("random");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
